// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: collects 5/10/20 coins, vends one of N_ITEMS
// products at per-item prices and pays remaining credit back as 10/5 change pulses.
module vending_machine_multi #(
   parameter int unsigned N_ITEMS    = 4,
   parameter int unsigned CREDIT_W   = 8,
   parameter int unsigned MAX_CREDIT = 50,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd10, 8'd25, 8'd20, 8'd15},
   localparam int unsigned SEL_W     = $clog2(N_ITEMS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin,
   input  logic [SEL_W-1:0]    sel,
   input  logic                sel_valid,
   input  logic                cancel,
   output logic                vend,
   output logic [SEL_W-1:0]    vend_item,
   output logic                chg5,
   output logic                chg10,
   output logic                coin_reject,
   output logic                nack,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int unsigned CW1 = CREDIT_W + 1;

   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] VEND    = 2'd1;
   localparam logic [1:0] CHANGE  = 2'd2;

   logic [1:0]          state, state_d;
   logic [CREDIT_W-1:0] credit_d;
   logic                vend_d, chg5_d, chg10_d, coin_reject_d, nack_d;
   logic [SEL_W-1:0]    vend_item_d;

   logic [CW1-1:0]      coin_val, price, credit_x, coin_sum;
   logic                sel_ok, chg_big;
   logic [CREDIT_W-1:0] chg_credit;

   // price lookup and index validity; indices >= N_ITEMS are never matched
   always_comb begin
      sel_ok = 1'b0;
      price  = '0;
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_ok = 1'b1;
            price  = CW1'(PRICES[i*CREDIT_W +: CREDIT_W]);
         end
      end
   end

   always_comb begin
      case (coin)
         2'b01:   coin_val = CW1'(5);
         2'b10:   coin_val = CW1'(10);
         2'b11:   coin_val = CW1'(20);
         default: coin_val = '0;
      endcase
   end

   assign credit_x   = {1'b0, credit};
   assign coin_sum   = credit_x + coin_val;
   assign chg_big    = credit >= CREDIT_W'(10);
   assign chg_credit = credit - (chg_big ? CREDIT_W'(10) : CREDIT_W'(5));

   // next state and next registered outputs
   always_comb begin
      state_d       = state;
      credit_d      = credit;
      vend_d        = 1'b0;
      vend_item_d   = '0;
      chg5_d        = 1'b0;
      chg10_d       = 1'b0;
      coin_reject_d = 1'b0;
      nack_d        = 1'b0;
      case (state)
         COLLECT: begin
            if (cancel) begin
               coin_reject_d = (coin != 2'b00);
               if (credit != '0) begin
                  state_d  = CHANGE;
                  credit_d = chg_credit;
                  chg10_d  = chg_big;
                  chg5_d   = !chg_big;
               end
            end else if (sel_valid) begin
               coin_reject_d = (coin != 2'b00);
               if (sel_ok && (credit_x >= price)) begin
                  state_d     = VEND;
                  credit_d    = CREDIT_W'(credit_x - price);
                  vend_d      = 1'b1;
                  vend_item_d = sel;
               end else begin
                  nack_d = 1'b1;
               end
            end else if (coin != 2'b00) begin
               if (coin_sum <= CW1'(MAX_CREDIT)) credit_d = CREDIT_W'(coin_sum);
               else                              coin_reject_d = 1'b1;
            end
         end
         VEND, CHANGE: begin
            // a change pulse is issued on every cycle entered with credit left
            coin_reject_d = (coin != 2'b00);
            if (credit != '0) begin
               state_d  = CHANGE;
               credit_d = chg_credit;
               chg10_d  = chg_big;
               chg5_d   = !chg_big;
            end else begin
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= COLLECT;
         credit      <= '0;
         vend        <= 1'b0;
         vend_item   <= '0;
         chg5        <= 1'b0;
         chg10       <= 1'b0;
         coin_reject <= 1'b0;
         nack        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_d;
         credit      <= credit_d;
         vend        <= vend_d;
         vend_item   <= vend_item_d;
         chg5        <= chg5_d;
         chg10       <= chg10_d;
         coin_reject <= coin_reject_d;
         nack        <= nack_d;
         busy        <= (state_d != COLLECT);
      end
   end

endmodule
